// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network datapath stages.
// Holds default word widths, the layer-run FSM encoding, the token carried
// alongside memory reads, and helpers producing signed saturation bounds.
package nn_pkg;

  localparam int unsigned DefDataW    = 8;
  localparam int unsigned DefAccW     = 20;
  localparam int unsigned DefFracBits = 4;
  localparam int unsigned DefMemLat   = 1;
  localparam int unsigned AddrW       = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } state_e;

  // Travels with each read address so it meets the returned memory data.
  typedef struct packed {
    logic             valid;
    logic             last;
    logic             fin;
    logic [AddrW-1:0] addr;
  } token_t;

  // Signed range bounds of a w-bit two's complement word (w <= 31).
  function automatic int sat_max(input int unsigned w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int sat_min(input int unsigned w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/nn_relu_sat.sv
// Fixed-point activation: arithmetic right shift by FRAC_BITS followed by a
// saturating ReLU into an unsigned-range DATA_W result (0 .. 2^(DATA_W-1)-1).
// Ports:
//   acc_i : signed accumulator value (ACC_W bits)
//   act_o : activated result (DATA_W bits)
module nn_relu_sat
  import nn_pkg::*;
#(
  parameter int unsigned ACC_W     = DefAccW,
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned FRAC_BITS = DefFracBits
) (
  input  logic signed [ACC_W-1:0]  acc_i,
  output logic        [DATA_W-1:0] act_o
);

  localparam logic [DATA_W-1:0] ActMax = DATA_W'(sat_max(DATA_W));

  logic signed [ACC_W-1:0] shifted;

  assign shifted = acc_i >>> FRAC_BITS;

  always_comb begin
    if (shifted[ACC_W-1]) begin
      act_o = '0;
    end else if (|shifted[ACC_W-2:DATA_W-1]) begin
      // Any set bit at or above the result sign position exceeds ActMax.
      act_o = ActMax;
    end else begin
      act_o = shifted[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/neuron_mac_unit.sv
// Signed multiply-accumulate stage behind the layer address generator.
// Each issued address carries a token down a MEM_LAT-deep delay line so it
// lines up with the returned weight/neuron words. Per neuron the products are
// summed with saturation, then shifted and ReLU-clamped and written back.
// Ports:
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   start_i                : layer start pulse (also drives the generator)
//   neuron_finished_i      : current address is a neuron's last input
//   finished_i             : current address is the layer's last input
//   neuro_write_addr_i     : write address of the current neuron
//   weight_data_i          : weight memory read data
//   neuro_data_i           : neuron memory read data
//   wr_en_o/wr_addr_o/wr_data_o : neuron memory write port
//   busy_o                 : run in progress (RUN or DRAIN)
//   done_o                 : one-cycle pulse after the layer's last write
module neuron_mac_unit
  import nn_pkg::*;
#(
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned ACC_W     = DefAccW,
  parameter int unsigned FRAC_BITS = DefFracBits,
  parameter int unsigned MEM_LAT   = DefMemLat
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              neuron_finished_i,
  input  logic              finished_i,
  input  logic [AddrW-1:0]  neuro_write_addr_i,
  input  logic [DATA_W-1:0] weight_data_i,
  input  logic [DATA_W-1:0] neuro_data_i,
  output logic              wr_en_o,
  output logic [AddrW-1:0]  wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int unsigned    ExtW   = ACC_W + 1 - 2 * DATA_W;
  localparam logic [ACC_W-1:0] AccMax = ACC_W'(sat_max(ACC_W));
  localparam logic [ACC_W-1:0] AccMin = ACC_W'(sat_min(ACC_W));

  state_e state_q, state_d;

  token_t tok_in;
  token_t tok_mem;
  token_t pipe_q [MEM_LAT];
  logic   pipe_busy;
  logic   eff_last;

  logic [2*DATA_W-1:0] prod;
  logic [ACC_W:0]      prod_ext, base_ext, sum_wide;
  logic [ACC_W-1:0]    sum_sat;
  logic [DATA_W-1:0]   act;

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              first_q, first_d;
  logic              wr_en_q, wr_en_d;
  logic              wr_fin_q, wr_fin_d;
  logic [AddrW-1:0]  wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  // Start cycles issue nothing: the generator holds its counters at zero.
  always_comb begin
    tok_in.valid = (state_q == StRun) && !start_i;
    tok_in.last  = neuron_finished_i;
    tok_in.fin   = finished_i;
    tok_in.addr  = neuro_write_addr_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MEM_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= tok_in;
      for (int i = 1; i < MEM_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  always_comb begin
    pipe_busy = 1'b0;
    for (int i = 0; i < MEM_LAT; i++) pipe_busy = pipe_busy | pipe_q[i].valid;
  end

  assign tok_mem  = pipe_q[MEM_LAT-1];
  // A final input also closes its neuron so nothing is left unwritten.
  assign eff_last = tok_mem.last | tok_mem.fin;

  // Operands sign-extended so the low 2*DATA_W bits hold the signed product.
  assign prod = {{DATA_W{weight_data_i[DATA_W-1]}}, weight_data_i} *
                {{DATA_W{neuro_data_i[DATA_W-1]}}, neuro_data_i};

  always_comb begin
    prod_ext = {{ExtW{prod[2*DATA_W-1]}}, prod};
    base_ext = first_q ? '0 : {acc_q[ACC_W-1], acc_q};
    sum_wide = base_ext + prod_ext;
    if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
      sum_sat = sum_wide[ACC_W] ? AccMin : AccMax;
    end else begin
      sum_sat = sum_wide[ACC_W-1:0];
    end
  end

  nn_relu_sat #(
    .ACC_W    (ACC_W),
    .DATA_W   (DATA_W),
    .FRAC_BITS(FRAC_BITS)
  ) u_relu (
    .acc_i(sum_sat),
    .act_o(act)
  );

  always_comb begin
    acc_d     = acc_q;
    first_d   = first_q;
    wr_en_d   = 1'b0;
    wr_fin_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (tok_mem.valid) begin
      acc_d   = sum_sat;
      first_d = eff_last;
      if (eff_last) begin
        wr_en_d   = 1'b1;
        wr_fin_d  = tok_mem.fin;
        wr_addr_d = tok_mem.addr;
        wr_data_d = act;
      end
    end else if (state_q == StIdle) begin
      first_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_i) state_d = StRun;
      StRun:   if (tok_in.valid && tok_in.fin) state_d = StDrain;
      StDrain: if (!pipe_busy && wr_en_q && wr_fin_q) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      first_q   <= 1'b1;
      wr_en_q   <= 1'b0;
      wr_fin_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      first_q   <= first_d;
      wr_en_q   <= wr_en_d;
      wr_fin_q  <= wr_fin_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
  assign busy_o    = (state_q == StRun) || (state_q == StDrain);
  assign done_o    = (state_q == StDone);

endmodule

// File: tb/tb_neuron_mac_unit.sv
// Directed bench for neuron_mac_unit. Four instances share the generator-side
// stimulus: f0 (FRAC_BITS=0, MEM_LAT=1), f4 (FRAC_BITS=4, ACC_W=16, MEM_LAT=1),
// l2 and l3 (FRAC_BITS=0, MEM_LAT=2/3). A delay chain models memory latency.
module tb_neuron_mac_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, nf, fin;
  logic [7:0] addr;
  logic [7:0] w_s, x_s, w_d1, x_d1, w_d2, x_d2, w_d3, x_d3;

  logic       en_f0, en_f4, en_l2, en_l3;
  logic [7:0] a_f0, a_f4, a_l2, a_l3;
  logic [7:0] d_f0, d_f4, d_l2, d_l3;
  logic       b_f0, b_f4, b_l2, b_l3;
  logic       dn_f0, dn_f4, dn_l2, dn_l3;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  // Memory model: data for the address presented in cycle t appears at t+k.
  always @(posedge clk) begin
    w_d1 <= w_s;  x_d1 <= x_s;
    w_d2 <= w_d1; x_d2 <= x_d1;
    w_d3 <= w_d2; x_d3 <= x_d2;
  end

  neuron_mac_unit #(.DATA_W(8), .ACC_W(20), .FRAC_BITS(0), .MEM_LAT(1)) u_f0 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .neuron_finished_i(nf),
    .finished_i(fin), .neuro_write_addr_i(addr), .weight_data_i(w_d1),
    .neuro_data_i(x_d1), .wr_en_o(en_f0), .wr_addr_o(a_f0), .wr_data_o(d_f0),
    .busy_o(b_f0), .done_o(dn_f0));

  neuron_mac_unit #(.DATA_W(8), .ACC_W(16), .FRAC_BITS(4), .MEM_LAT(1)) u_f4 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .neuron_finished_i(nf),
    .finished_i(fin), .neuro_write_addr_i(addr), .weight_data_i(w_d1),
    .neuro_data_i(x_d1), .wr_en_o(en_f4), .wr_addr_o(a_f4), .wr_data_o(d_f4),
    .busy_o(b_f4), .done_o(dn_f4));

  neuron_mac_unit #(.DATA_W(8), .ACC_W(20), .FRAC_BITS(0), .MEM_LAT(2)) u_l2 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .neuron_finished_i(nf),
    .finished_i(fin), .neuro_write_addr_i(addr), .weight_data_i(w_d2),
    .neuro_data_i(x_d2), .wr_en_o(en_l2), .wr_addr_o(a_l2), .wr_data_o(d_l2),
    .busy_o(b_l2), .done_o(dn_l2));

  neuron_mac_unit #(.DATA_W(8), .ACC_W(20), .FRAC_BITS(0), .MEM_LAT(3)) u_l3 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .neuron_finished_i(nf),
    .finished_i(fin), .neuro_write_addr_i(addr), .weight_data_i(w_d3),
    .neuro_data_i(x_d3), .wr_en_o(en_l3), .wr_addr_o(a_l3), .wr_data_o(d_l3),
    .busy_o(b_l3), .done_o(dn_l3));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic st, input logic n, input logic f, input logic [7:0] a,
                       input logic [7:0] w, input logic [7:0] x);
    start = st; nf = n; fin = f; addr = a; w_s = w; x_s = x;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 8'h00, 8'd0, 8'd0);
    @(negedge clk);
    check("rst_wr_en",   32'(en_f0), 32'd0);
    check("rst_wr_addr", 32'(a_f0),  32'd0);
    check("rst_wr_data", 32'(d_f0),  32'd0);
    check("rst_busy",    32'(b_f0),  32'd0);
    check("rst_done",    32'(dn_f0), 32'd0);
    rst_n = 1'b1;
    tick();
    tick();

    // Two neurons x 2 inputs; latency sweep on l2/l3.
    drive(1, 0, 0, 8'h00, 8'd0, 8'd0);    tick();
    check("t1_busy", 32'(b_f0), 32'd1);
    drive(0, 0, 0, 8'h10, 8'd2, 8'd4);    tick();
    drive(0, 1, 0, 8'h10, 8'd3, 8'd5);    tick();
    check("t1_no_early_wr", 32'(en_f0), 32'd0);
    drive(0, 0, 0, 8'h11, 8'hFF, 8'd7);   tick();
    check("t1_n0_en",   32'(en_f0), 32'd1);
    check("t1_n0_addr", 32'(a_f0),  32'h10);
    check("t1_n0_data", 32'(d_f0),  32'd23);
    check("t1_f4_data", 32'(d_f4),  32'd1);
    check("lat2_n0_not_yet", 32'(en_l2), 32'd0);
    drive(0, 1, 1, 8'h11, 8'd1, 8'd2);    tick();
    check("t1_gap_en",   32'(en_f0), 32'd0);
    check("t1_busy_mid", 32'(b_f0),  32'd1);
    check("lat2_n0_en",   32'(en_l2), 32'd1);
    check("lat2_n0_addr", 32'(a_l2),  32'h10);
    check("lat2_n0_data", 32'(d_l2),  32'd23);
    check("lat3_n0_not_yet", 32'(en_l3), 32'd0);
    drive(0, 0, 0, 8'h00, 8'd0, 8'd0);    tick();
    check("t1_n1_en",   32'(en_f0), 32'd1);
    check("t1_n1_addr", 32'(a_f0),  32'h11);
    check("t1_n1_relu", 32'(d_f0),  32'd0);
    check("t1_done_not_yet", 32'(dn_f0), 32'd0);
    check("lat3_n0_en",   32'(en_l3), 32'd1);
    check("lat3_n0_addr", 32'(a_l3),  32'h10);
    check("lat3_n0_data", 32'(d_l3),  32'd23);
    tick();
    check("t1_done",      32'(dn_f0), 32'd1);
    check("t1_en_off",    32'(en_f0), 32'd0);
    check("t1_busy_off",  32'(b_f0),  32'd0);
    check("lat2_n1_en",   32'(en_l2), 32'd1);
    check("lat2_n1_addr", 32'(a_l2),  32'h11);
    tick();
    check("t1_done_pulse", 32'(dn_f0), 32'd0);
    check("lat2_done",     32'(dn_l2), 32'd1);
    check("lat3_n1_en",    32'(en_l3), 32'd1);
    check("lat3_n1_addr",  32'(a_l3),  32'h11);
    tick();
    check("lat3_done", 32'(dn_l3), 32'd1);
    tick();

    // Fixed point, single-input neurons back to back.
    drive(1, 0, 0, 8'h00, 8'd0, 8'd0);    tick();
    drive(0, 1, 0, 8'h20, 8'd64, 8'd8);   tick();
    drive(0, 1, 1, 8'h21, 8'd127, 8'd127); tick();
    check("fx_a_en",    32'(en_f4), 32'd1);
    check("fx_a_addr",  32'(a_f4),  32'h20);
    check("fx_a_data",  32'(d_f4),  32'd32);
    check("fx_f0_clamp", 32'(d_f0), 32'd127);
    drive(0, 0, 0, 8'h00, 8'd0, 8'd0);    tick();
    check("fx_b_en",   32'(en_f4), 32'd1);
    check("fx_b_addr", 32'(a_f4),  32'h21);
    check("fx_b_clamp", 32'(d_f4), 32'd127);
    tick();
    check("fx_done", 32'(dn_f4), 32'd1);
    tick(); tick(); tick();

    // Accumulator saturation at ACC_W=16, with a start pulse mid-run.
    drive(1, 0, 0, 8'h00, 8'd0, 8'd0);     tick();
    drive(0, 0, 0, 8'h30, 8'd127, 8'd127); tick();
    drive(1, 1, 1, 8'h31, 8'd100, 8'd100); tick();
    check("st_busy",    32'(b_f4),  32'd1);
    check("st_no_wr_a", 32'(en_f4), 32'd0);
    drive(0, 0, 0, 8'h30, 8'd127, 8'd127); tick();
    check("st_no_wr_b", 32'(en_f4), 32'd0);
    check("st_busy_b",  32'(b_f4),  32'd1);
    drive(0, 0, 0, 8'h30, 8'd127, 8'd127); tick();
    drive(0, 1, 1, 8'h30, 8'd127, 8'd127); tick();
    drive(0, 0, 0, 8'h00, 8'd0, 8'd0);     tick();
    check("sat_en",   32'(en_f4), 32'd1);
    check("sat_addr", 32'(a_f4),  32'h30);
    check("sat_data", 32'(d_f4),  32'd127);
    check("sat_f0_data", 32'(d_f0), 32'd127);
    tick();
    check("sat_done", 32'(dn_f4), 32'd1);
    tick(); tick(); tick(); tick();

    // Asynchronous reset mid-run with a nonzero partial sum.
    drive(1, 0, 0, 8'h00, 8'd0, 8'd0);    tick();
    drive(0, 0, 0, 8'h40, 8'd5, 8'd5);    tick();
    drive(0, 0, 0, 8'h40, 8'd5, 8'd5);    tick();
    check("ar_busy_before", 32'(b_f0), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_busy",    32'(b_f0),  32'd0);
    check("ar_wr_en",   32'(en_f0), 32'd0);
    check("ar_wr_addr", 32'(a_f0),  32'd0);
    check("ar_wr_data", 32'(d_f0),  32'd0);
    check("ar_done",    32'(dn_f0), 32'd0);
    check("ar_l3_busy", 32'(b_l3),  32'd0);
    @(negedge clk);
    drive(0, 1, 1, 8'h42, 8'd9, 8'd9);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("ar_no_wr",   32'(en_f0), 32'd0);
      check("ar_idle",    32'(b_f0),  32'd0);
    end
    drive(1, 0, 0, 8'h00, 8'd0, 8'd0);    tick();
    drive(0, 1, 1, 8'h41, 8'd3, 8'd3);    tick();
    drive(0, 0, 0, 8'h00, 8'd0, 8'd0);    tick();
    check("ar_fresh_en",   32'(en_f0), 32'd1);
    check("ar_fresh_addr", 32'(a_f0),  32'h41);
    check("ar_fresh_data", 32'(d_f0),  32'd9);
    tick();
    check("ar_fresh_done", 32'(dn_f0), 32'd1);
    tick(); tick(); tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
